alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the next-generation datapath. It generalises the combinational 32-bit ALU in three ways: configurable width, registered outputs behind a valid/ready handshake, and iterative unsigned multiply, divide and remainder. It sits between the decode/register-read stage and write-back, and stalls the pipeline while an iterative operation is in flight.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- valid_i  in  1  operation request; operands and opcode are sampled when valid_i && ready_o.
- ready_o  out  1  block can accept a request.
- src1_i  in  WIDTH  operand A; signed for slt/overflow purposes.
- src2_i  in  WIDTH  operand B; signed for slt/overflow purposes.
- ctrl_i  in  4  opcode.
- valid_o  out  1  result available.
- ready_i  in  1  consumer accepts the result.
- result_o  out  WIDTH  registered result.
- zero_o  out  1  result_o == 0, valid for every opcode.
- ovf_o  out  1  signed overflow; add/sub only, 0 for all other opcodes.

## Operation
- Opcodes:
  - 0000 and
  - 0001 or
  - 0010 add
  - 0110 sub
  - 0111 slt: 1 if signed A < B, else 0
  - 1100 nor
  - 1000 mul: low WIDTH bits of A×B
  - 1001 divu: unsigned quotient
  - 1010 remu: unsigned remainder
  - any other opcode: result 0, zero_o 1, ovf_o 0 (single-cycle path).
- Overflow:
  - add: operands share a sign and the sum's sign differs.
  - sub: operands differ in sign and the result's sign differs from A.
- States: IDLE, MUL, DIV, DONE.
  - IDLE: ready_o=1. On accept, single-cycle opcodes compute and register the result, then go to DONE. mul loads multiplicand/multiplier, clears the accumulator and goes to MUL. divu/remu load the dividend and clear the partial remainder; a zero divisor goes straight to DONE, otherwise to DIV.
  - MUL: shift-add, one multiplier bit per cycle, LSB first, for exactly WIDTH cycles, then DONE.
  - DIV: restoring division, one quotient bit per cycle, MSB first, for exactly WIDTH cycles, then DONE. divu outputs the quotient; remu outputs the remainder.
  - DONE: valid_o=1. Hold result_o, zero_o and ovf_o stable until ready_i=1, then return to IDLE.
- Iteration counter is $clog2(WIDTH)+1 bits, loaded with WIDTH on entry and decremented each iteration; the exit condition is count reaching 1 while in MUL/DIV.
- Divide by zero: divu gives all ones; remu gives the dividend. Both reach DONE in 1 cycle with ovf_o=0.
- ready_o=0 in MUL, DIV and DONE. Requests presented then are neither sampled nor queued.
- All arithmetic wraps modulo 2^WIDTH.
- Operand registers are captured on accept; input changes during iteration have no effect.

## Timing
- Reset (asynchronous, rst_i=0): state=IDLE, ready_o=1, valid_o=0, result_o=0, zero_o=1, ovf_o=0, counter=0.
- Reset asserted mid-operation aborts immediately. No result is produced after release.
- Single-cycle op accepted at edge N: valid_o=1 after edge N+1.
- mul, or divu/remu with a nonzero divisor, accepted at edge N: valid_o=1 after edge N+WIDTH+1.
- divu/remu with a zero divisor: valid_o=1 after edge N+1.
- Result handshake: the result is consumed at the first edge where valid_o && ready_i. At that edge, valid_o→0 and ready_o→1.
- Minimum spacing between accepts is 2 cycles: DONE and IDLE cannot overlap.
- ready_i=1 throughout still costs the DONE cycle.
- result_o keeps the last delivered value in IDLE/MUL/DIV; only DONE entry updates it.
- valid_o and ready_o are driven from state registers only, with no combinational path from the inputs.

## Test plan
- Reset and ALU ops (WIDTH=32):
  - After reset release: ready_o=1, valid_o=0, zero_o=1.
  - add 0x7FFFFFFF+1: result 0x80000000, ovf_o=1, valid 1 cycle after accept.
  - sub 5−5: result 0, zero_o=1, ovf_o=0.
  - slt −1<1: result 1.
  - nor 0,0: result 0xFFFFFFFF.
- Multiply: mul 0xFFFFFFFF×0xFFFFFFFF → result 1, valid_o exactly 33 cycles after accept; ready_o=0 throughout. A valid_i pulse with other operands mid-iteration is ignored.
- Divide: divu 100/7 → 14; remu 100/7 → 2; each takes 33 cycles. divu 9/0 → 0xFFFFFFFF and remu 9/0 → 9, each with valid 1 cycle after accept.
- Back-pressure:
  - Hold ready_i=0 for 10 cycles in DONE: result_o, zero_o and ovf_o stable, ready_o=0.
  - Raise ready_i: IDLE next cycle.
  - Back-to-back accepts are spaced exactly 2 cycles apart.
- Reset mid-mul at iteration 10: outputs go to reset values asynchronously. After release, no valid_o appears, and a new add 2+3 returns 5.
- Parameter sweep at WIDTH=8:
  - mul 15×17 → 0xFF after 9 cycles.
  - divu 200/3 → 66 after 9 cycles.
  - 200 randomised ops checked against a reference model.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready handshake on both sides.
//
// Single-cycle ops (and, or, add, sub, slt, nor, unknown opcodes) go straight
// from IDLE to DONE on accept. mul iterates shift-add over WIDTH cycles, LSB
// first. divu/remu iterate restoring division over WIDTH cycles, MSB first.
// A zero divisor short-circuits to DONE.
//
// Parameters:
//   WIDTH     operand/result width in bits (must be >= 4)
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous reset, active-low
//   valid_i   request; src1_i/src2_i/ctrl_i sampled when valid_i && ready_o
//   ready_o   high only in IDLE
//   src1_i    operand A (signed for slt/overflow)
//   src2_i    operand B (signed for slt/overflow)
//   ctrl_i    opcode
//   valid_o   high only in DONE
//   ready_i   consumer accepts the result
//   result_o  registered result, held until the next DONE entry
//   zero_o    result_o == 0
//   ovf_o     signed overflow for add/sub, 0 otherwise
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;      // multiplicand (shifts left) / divisor
  logic [WIDTH-1:0] opb_q, opb_d;      // multiplier (shifts right) / dividend->quotient
  logic [WIDTH-1:0] acc_q, acc_d;      // product accumulator / partial remainder
  logic             rem_sel_q, rem_sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] single_res_s;
  logic             single_ovf_s;
  logic [WIDTH-1:0] zdiv_res_s;
  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH:0]   div_sh_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_rem_s;
  logic [WIDTH-1:0] div_quo_s;

  // Result of the single-cycle opcodes; unknown opcodes yield 0.
  function automatic logic [WIDTH-1:0] alu_logic(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:  r = ~(a | b);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Signed overflow flag; only add and sub can set it.
  function automatic logic alu_ovf(input logic [3:0] op,
                                   input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] d;
    logic             o;
    s = a + b;
    d = a - b;
    case (op)
      OP_ADD:  o = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  o = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  assign single_res_s = alu_logic(ctrl_i, src1_i, src2_i);
  assign single_ovf_s = alu_ovf(ctrl_i, src1_i, src2_i);
  // Divide by zero: remu returns the dividend, divu returns all ones.
  assign zdiv_res_s   = (ctrl_i == OP_REMU) ? src1_i : {WIDTH{1'b1}};

  // One shift-add step; the low WIDTH bits are all that survive.
  assign mul_acc_s = acc_q + (opb_q[0] ? opa_q : {WIDTH{1'b0}});

  // One restoring-division step. The shifted remainder needs an extra bit;
  // when it is >= divisor the difference fits in WIDTH bits again.
  assign div_sh_s  = {acc_q, opb_q[WIDTH-1]};
  assign div_ge_s  = (div_sh_s >= {1'b0, opa_q});
  assign div_rem_s = div_ge_s ? (div_sh_s[WIDTH-1:0] - opa_q) : div_sh_s[WIDTH-1:0];
  assign div_quo_s = {opb_q[WIDTH-2:0], div_ge_s};

  // Next-state and datapath update for the IDLE/MUL/DIV/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    rem_sel_d = rem_sel_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          case (ctrl_i)
            OP_MUL: begin
              opa_d   = src1_i;
              opb_d   = src2_i;
              acc_d   = {WIDTH{1'b0}};
              cnt_d   = CNT_INIT;
              state_d = S_MUL;
            end
            OP_DIVU, OP_REMU: begin
              opa_d     = src2_i;
              opb_d     = src1_i;
              acc_d     = {WIDTH{1'b0}};
              rem_sel_d = (ctrl_i == OP_REMU);
              if (src2_i == {WIDTH{1'b0}}) begin
                result_d = zdiv_res_s;
                zero_d   = (zdiv_res_s == {WIDTH{1'b0}});
                ovf_d    = 1'b0;
                state_d  = S_DONE;
              end else begin
                cnt_d    = CNT_INIT;
                state_d  = S_DIV;
              end
            end
            default: begin
              result_d = single_res_s;
              zero_d   = (single_res_s == {WIDTH{1'b0}});
              ovf_d    = single_ovf_s;
              state_d  = S_DONE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d = mul_acc_s;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = mul_acc_s;
          zero_d   = (mul_acc_s == {WIDTH{1'b0}});
          ovf_d    = 1'b0;
          state_d  = S_DONE;
        end else begin
          state_d  = S_MUL;
        end
      end
      S_DIV: begin
        acc_d = div_rem_s;
        opb_d = div_quo_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = rem_sel_q ? div_rem_s : div_quo_s;
          zero_d   = rem_sel_q ? (div_rem_s == {WIDTH{1'b0}}) : (div_quo_s == {WIDTH{1'b0}});
          ovf_d    = 1'b0;
          state_d  = S_DONE;
        end else begin
          state_d  = S_DIV;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand and result registers; reset aborts any operation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      opa_q     <= {WIDTH{1'b0}};
      opb_q     <= {WIDTH{1'b0}};
      acc_q     <= {WIDTH{1'b0}};
      rem_sel_q <= 1'b0;
      result_q  <= {WIDTH{1'b0}};
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      rem_sel_q <= rem_sel_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit and an 8-bit instance share one clock and one
// scoreboard. Stimulus pushes the reference model's answer on accept; a
// negedge monitor checks ready/valid timing and pops on result consumption.
module tb_alu_mc;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    int          lat;
    int          acc;
    bit          dut;
  } exp_t;

  logic        clk, rst_n;
  logic        v32_i, r32_o, v32_o, rdy32_i, z32_o, o32_o;
  logic [31:0] a32, b32, res32;
  logic [3:0]  c32;
  logic        v8_i, r8_o, v8_o, rdy8_i, z8_o, o8_o;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  c8;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_mc #(.WIDTH(32)) u_dut32 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(v32_i), .ready_o(r32_o),
    .src1_i(a32), .src2_i(b32), .ctrl_i(c32), .valid_o(v32_o),
    .ready_i(rdy32_i), .result_o(res32), .zero_o(z32_o), .ovf_o(o32_o)
  );

  alu_mc #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(v8_i), .ready_o(r8_o),
    .src1_i(a8), .src2_i(b8), .ctrl_i(c8), .valid_o(v8_o),
    .ready_i(rdy8_i), .result_o(res8), .zero_o(z8_o), .ovf_o(o8_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit values.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int w);
    exp_t e;
    longint unsigned msk, ua, ub, r;
    longint sa, sb, s, maxp, minn;
    msk  = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & msk;
    ub   = {32'd0, b} & msk;
    sa   = ua[w-1] ? (longint'(ua) - longint'(msk) - 64'sd1) : longint'(ua);
    sb   = ub[w-1] ? (longint'(ub) - longint'(msk) - 64'sd1) : longint'(ub);
    maxp = longint'(msk >> 1);
    minn = -maxp - 64'sd1;
    r = 64'd0; e.o = 1'b0; e.lat = 1;
    case (op)
      4'b0000: r = ua & ub;
      4'b0001: r = ua | ub;
      4'b0010: begin s = sa + sb; e.o = (s > maxp) || (s < minn); r = $unsigned(s) & msk; end
      4'b0110: begin s = sa - sb; e.o = (s > maxp) || (s < minn); r = $unsigned(s) & msk; end
      4'b0111: r = (sa < sb) ? 64'd1 : 64'd0;
      4'b1100: r = ~(ua | ub) & msk;
      4'b1000: begin r = (ua * ub) & msk; e.lat = w + 1; end
      4'b1001: if (ub == 64'd0) r = msk; else begin r = ua / ub; e.lat = w + 1; end
      4'b1010: if (ub == 64'd0) r = ua;  else begin r = ua % ub; e.lat = w + 1; end
      default: r = 64'd0;
    endcase
    e.res = r[31:0];
    e.z   = (r == 64'd0);
    e.acc = 0;
    e.dut = 1'b0;
    return e;
  endfunction

  task automatic drive(input bit d, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (d) begin
      v8_i = v; c8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      v32_i = v; c32 = op; a32 = a; b32 = b;
    end
  endtask

  // Present a request until accepted, then push the model's answer.
  task automatic issue(input bit d, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int acc);
    exp_t e;
    bit   got;
    got = 1'b0;
    acc = 0;
    drive(d, 1'b1, op, a, b);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = d ? r8_o : r32_o;
    end
    check1(d ? "w8 accept" : "w32 accept", got, 1'b1);
    if (got) begin
      acc = cyc + 1;
      @(posedge clk);
      e = model(op, a, b, d ? 8 : 32);
      e.acc = acc;
      e.dut = d;
      sb_q.push_back(e);
    end else begin
      @(posedge clk);
    end
    #1 drive(d, 1'b0, op, a, b);
  endtask

  task automatic wait_idle();
    bit empty_f;
    empty_f = 1'b0;
    for (int i = 0; i < 300 && !empty_f; i++) begin
      @(negedge clk);
      empty_f = (sb_q.size() == 0);
    end
    check1("result drained", empty_f, 1'b1);
    if (!empty_f) sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Monitor: ready/valid expected from the scoreboard head and elapsed cycles.
  task automatic mon(input bit d, input logic vld, input logic rdy, input logic [31:0] res,
                     input logic z, input logic o, input logic rdyi);
    bit    mine, exp_v;
    string p;
    p     = d ? "w8" : "w32";
    mine  = 1'b0;
    exp_v = 1'b0;
    if (sb_q.size() > 0) begin
      mine  = (sb_q[0].dut == d);
      exp_v = mine && ((cyc - sb_q[0].acc + 1) >= sb_q[0].lat);
    end
    check1({p, " ready_o"}, rdy, !mine);
    check1({p, " valid_o"}, vld, exp_v);
    if (vld && exp_v) begin
      check32({p, " result_o"}, res, sb_q[0].res);
      check1({p, " zero_o"}, z, sb_q[0].z);
      check1({p, " ovf_o"}, o, sb_q[0].o);
      if (rdyi) void'(sb_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0, v32_o, r32_o, res32, z32_o, o32_o, rdy32_i);
    mon(1'b1, v8_o, r8_o, {24'd0, res8}, z8_o, o8_o, rdy8_i);
  end

  initial begin
    int acc1, acc2, sel, stall;
    logic [3:0] op;
    logic [3:0] ops_tbl [9];
    logic [31:0] ra, rb;
    ops_tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                4'b1100, 4'b1000, 4'b1001, 4'b1010};
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
    rdy32_i = 1'b1;
    rdy8_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check1("reset ready_o", r32_o, 1'b1);
    check1("reset valid_o", v32_o, 1'b0);
    check1("reset zero_o", z32_o, 1'b1);
    check32("reset result_o", res32, 32'd0);
    @(posedge clk);
    #1;

    // Single-cycle ops, WIDTH=32.
    issue(1'b0, 4'b0010, 32'h7FFF_FFFF, 32'd1, acc1);        wait_idle();
    issue(1'b0, 4'b0110, 32'd5, 32'd5, acc1);                wait_idle();
    issue(1'b0, 4'b0111, 32'hFFFF_FFFF, 32'd1, acc1);        wait_idle();
    issue(1'b0, 4'b1100, 32'd0, 32'd0, acc1);                wait_idle();
    issue(1'b0, 4'b0110, 32'h8000_0000, 32'd1, acc1);        wait_idle();
    issue(1'b0, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, acc1); wait_idle();
    issue(1'b0, 4'b0001, 32'hF000_0000, 32'h0000_000F, acc1); wait_idle();
    issue(1'b0, 4'b0011, 32'h1234_5678, 32'h1, acc1);        wait_idle();

    // mul with an ignored request mid-iteration.
    issue(1'b0, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc1);
    repeat (5) @(posedge clk);
    #1 drive(1'b0, 1'b1, 4'b0010, 32'd3, 32'd4);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 4'b0010, 32'd3, 32'd4);
    wait_idle();

    // Division, including divide by zero.
    issue(1'b0, 4'b1001, 32'd100, 32'd7, acc1); wait_idle();
    issue(1'b0, 4'b1010, 32'd100, 32'd7, acc1); wait_idle();
    issue(1'b0, 4'b1001, 32'd9, 32'd0, acc1);   wait_idle();
    issue(1'b0, 4'b1010, 32'd9, 32'd0, acc1);   wait_idle();

    // Back-pressure: hold the result in DONE for 10+ cycles.
    rdy32_i = 1'b0;
    issue(1'b0, 4'b0010, 32'h7FFF_FFFF, 32'd1, acc1);
    repeat (11) @(posedge clk);
    #1 rdy32_i = 1'b1;
    wait_idle();
    check1("idle after release ready_o", r32_o, 1'b1);

    // Back-to-back accepts.
    issue(1'b0, 4'b0010, 32'd10, 32'd20, acc1);
    issue(1'b0, 4'b0110, 32'd10, 32'd20, acc2);
    check32("accept spacing", 32'(acc2 - acc1), 32'd2);
    wait_idle();

    // Reset in the middle of a multiply.
    issue(1'b0, 4'b1000, 32'h0001_2345, 32'h0000_6789, acc1);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check1("async reset ready_o", r32_o, 1'b1);
    check1("async reset valid_o", v32_o, 1'b0);
    check32("async reset result_o", res32, 32'd0);
    check1("async reset zero_o", z32_o, 1'b1);
    check1("async reset ovf_o", o32_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(1'b0, 4'b0010, 32'd2, 32'd3, acc1); wait_idle();

    // WIDTH=8 directed and randomized.
    issue(1'b1, 4'b1000, 32'd15, 32'd17, acc1); wait_idle();
    issue(1'b1, 4'b1001, 32'd200, 32'd3, acc1); wait_idle();
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 9) op = 4'($urandom_range(0, 15));
      else          op = ops_tbl[sel];
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      stall = $urandom_range(0, 3);
      rdy8_i = (stall != 0);
      issue(1'b1, op, ra, rb, acc1);
      if (stall == 0) begin
        repeat ($urandom_range(1, 12)) @(posedge clk);
        #1 rdy8_i = 1'b1;
      end
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
